// File: rtl/text_renderer.sv
// Walks a NUL-terminated string in a synchronous text RAM and feeds the
// character renderer one glyph at a time, tracking a scaled cursor.
module text_renderer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned SIZE_W  = 4,
  parameter int unsigned FONT_W  = 5,
  parameter int unsigned FONT_H  = 7,
  parameter int unsigned Y_LIMIT = 240
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] text_base,
  input  logic [ADDR_W-1:0] max_len,
  input  logic [X_W-1:0]    origin_x,
  input  logic [Y_W-1:0]    origin_y,
  input  logic [SIZE_W-1:0] size,
  input  logic [X_W-1:0]    wrap_x,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [6:0]        mem_rdata,
  output logic [6:0]        char,
  output logic [X_W-1:0]    char_x,
  output logic [Y_W-1:0]    char_y,
  output logic [SIZE_W-1:0] char_size,
  output logic              char_enable,
  input  logic              char_finished,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XE = X_W + 1;
  localparam int unsigned YE = Y_W + 1;
  localparam int unsigned CE = ADDR_W + 1;
  localparam logic [6:0] CH_NUL = 7'h00;
  localparam logic [6:0] CH_NL  = 7'h0A;
  localparam logic [6:0] CH_SP  = 7'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RENDER, S_RELEASE, S_ADVANCE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [X_W-1:0]      org_x_q, org_x_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [X_W-1:0]      wrap_q, wrap_d;
  logic [XE-1:0]       x_q, x_d;
  logic [YE-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [6:0]          char_q, char_d;
  logic [X_W-1:0]      char_x_q, char_x_d;
  logic [Y_W-1:0]      char_y_q, char_y_d;
  logic [SIZE_W-1:0]   char_size_q, char_size_d;
  logic                char_enable_q, char_enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [XE-1:0] step_w, glyph_w, x_g;
  logic [YE-1:0] step_h, glyph_h, y_g;
  logic          wrap_c;
  logic [CE-1:0] cnt_inc;

  // Cursor sums saturate one bit wider than the screen so overflow always reads as out of bounds.
  function automatic logic [XE-1:0] sat_x(input logic [XE-1:0] a, input logic [XE-1:0] b);
    logic [XE:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[XE] ? {XE{1'b1}} : s[XE-1:0];
  endfunction

  function automatic logic [YE-1:0] sat_y(input logic [YE-1:0] a, input logic [YE-1:0] b);
    logic [YE:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[YE] ? {YE{1'b1}} : s[YE-1:0];
  endfunction

  always_comb begin
    step_w  = XE'(size_q) * XE'(FONT_W + 1);
    glyph_w = XE'(size_q) * XE'(FONT_W);
    step_h  = YE'(size_q) * YE'(FONT_H + 1);
    glyph_h = YE'(size_q) * YE'(FONT_H);
    wrap_c  = (sat_x(x_q, glyph_w) > XE'(wrap_q)) && (x_q != XE'(org_x_q));
    x_g     = wrap_c ? XE'(org_x_q) : x_q;
    y_g     = wrap_c ? sat_y(y_q, step_h) : y_q;
    cnt_inc = CE'(count_q) + CE'(1);
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    org_x_d       = org_x_q;
    size_d        = size_q;
    wrap_d        = wrap_q;
    x_d           = x_q;
    y_d           = y_q;
    count_d       = count_q;
    mem_addr_d    = mem_addr_q;
    char_d        = char_q;
    char_x_d      = char_x_q;
    char_y_d      = char_y_q;
    char_size_d   = char_size_q;
    char_enable_d = char_enable_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = max_len;
          org_x_d = origin_x;
          size_d  = (size == '0) ? SIZE_W'(1) : size;
          wrap_d  = wrap_x;
          x_d     = XE'(origin_x);
          y_d     = YE'(origin_y);
          count_d = '0;
          if (max_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            busy_d     = 1'b1;
            mem_addr_d = text_base;
            state_d    = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        char_d = mem_rdata;
        if (mem_rdata == CH_NUL) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (mem_rdata == CH_NL) begin
          x_d     = XE'(org_x_q);
          y_d     = sat_y(y_q, step_h);
          state_d = S_ADVANCE;
        end else if (mem_rdata == CH_SP) begin
          x_d     = sat_x(x_q, step_w);
          state_d = S_ADVANCE;
        end else begin
          x_d = x_g;
          y_d = y_g;
          if (sat_y(y_g, glyph_h) > YE'(Y_LIMIT)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            char_x_d      = X_W'(x_g);
            char_y_d      = Y_W'(y_g);
            char_size_d   = size_q;
            char_enable_d = 1'b1;
            state_d       = S_RENDER;
          end
        end
      end
      S_RENDER: begin
        if (char_finished) begin
          char_enable_d = 1'b0;
          x_d           = sat_x(x_q, step_w);
          state_d       = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_ADVANCE;
      S_ADVANCE: begin
        count_d = ADDR_W'(cnt_inc);
        if (cnt_inc == CE'(len_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          state_d    = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      org_x_q       <= '0;
      size_q        <= '0;
      wrap_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      count_q       <= '0;
      mem_addr_q    <= '0;
      char_q        <= '0;
      char_x_q      <= '0;
      char_y_q      <= '0;
      char_size_q   <= '0;
      char_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      org_x_q       <= org_x_d;
      size_q        <= size_d;
      wrap_q        <= wrap_d;
      x_q           <= x_d;
      y_q           <= y_d;
      count_q       <= count_d;
      mem_addr_q    <= mem_addr_d;
      char_q        <= char_d;
      char_x_q      <= char_x_d;
      char_y_q      <= char_y_d;
      char_size_q   <= char_size_d;
      char_enable_q <= char_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign char        = char_q;
  assign char_x      = char_x_q;
  assign char_y      = char_y_q;
  assign char_size   = char_size_q;
  assign char_enable = char_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_text_renderer.sv
// Scoreboard bench for text_renderer: expected glyphs/done pulses are queued
// by the stimulus and popped by a monitor watching char_enable and done.
module tb_text_renderer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] text_base, max_len;
  logic [8:0] origin_x, wrap_x;
  logic [7:0] origin_y;
  logic [3:0] size;
  logic [7:0] mem_addr;
  logic [6:0] mem_rdata;
  logic [6:0] char;
  logic [8:0] char_x;
  logic [7:0] char_y;
  logic [3:0] char_size;
  logic       char_enable, char_finished, busy, done;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  text_renderer dut (
    .clock(clock), .resetn(resetn), .start(start), .text_base(text_base),
    .max_len(max_len), .origin_x(origin_x), .origin_y(origin_y), .size(size),
    .wrap_x(wrap_x), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .char(char),
    .char_x(char_x), .char_y(char_y), .char_size(char_size),
    .char_enable(char_enable), .char_finished(char_finished), .busy(busy), .done(done)
  );

  // Synchronous text RAM
  logic [6:0] mem [256];
  always @(posedge clock) mem_rdata <= mem[mem_addr];

  // Renderer model: finished rises 5 cycles after enable, clears when enable drops
  logic       fin_ok;
  logic [3:0] fin_cnt;
  always @(posedge clock) begin
    if (!char_enable || !fin_ok) begin
      fin_cnt       <= '0;
      char_finished <= 1'b0;
    end else if (!char_finished) begin
      fin_cnt <= fin_cnt + 4'd1;
      if (fin_cnt == 4'd4) char_finished <= 1'b1;
    end
  end

  typedef struct {
    bit         is_done;
    logic [6:0] ch;
    logic [8:0] x;
    logic [7:0] y;
    logic [3:0] sz;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_glyph(input logic [6:0] c, input int x, input int y, input int s);
    exp_t e;
    e.is_done = 1'b0; e.ch = c; e.x = 9'(x); e.y = 8'(y); e.sz = 4'(s);
    sb.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.ch = '0; e.x = '0; e.y = '0; e.sz = '0;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per enable rise or done pulse; checks hold while enabled
  logic       en_prev = 1'b0;
  logic [6:0] h_ch;
  logic [8:0] h_x;
  logic [7:0] h_y;
  logic [3:0] h_sz;
  always @(negedge clock) begin
    exp_t e;
    if (char_enable && !en_prev) begin
      if (sb.size() == 0) check("unexpected_glyph", 1, 0);
      else begin
        e = sb.pop_front();
        check("kind_glyph", 0, int'(e.is_done));
        check("char", int'(char), int'(e.ch));
        check("char_x", int'(char_x), int'(e.x));
        check("char_y", int'(char_y), int'(e.y));
        check("char_size", int'(char_size), int'(e.sz));
      end
      h_ch = char; h_x = char_x; h_y = char_y; h_sz = char_size;
    end else if (char_enable && en_prev) begin
      check("hold_stable", int'({char, char_x, char_y, char_size}), int'({h_ch, h_x, h_y, h_sz}));
    end
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("kind_done", 1, int'(e.is_done));
      end
      check("busy_in_done", int'(busy), 0);
    end
    en_prev = char_enable;
  end

  // Start a job, scramble inputs after acceptance, and wait for done with a cycle bound
  task automatic run(input logic [7:0] b, input logic [7:0] len, input int ox, input int oy,
                     input int sz, input int wx, input bit exp_busy, input bit chk_lat);
    bit seen = 1'b0;
    text_base = b; max_len = len; origin_x = 9'(ox); origin_y = 8'(oy);
    size = 4'(sz); wrap_x = 9'(wx); start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0;
        text_base = 8'hFF; max_len = 8'hFF; origin_x = 9'h1F0; origin_y = 8'hF0;
        size = 4'hF; wrap_x = 9'd3;
        if (exp_busy) check("busy_after_start", int'(busy), 1);
      end
      if (c == 2 && chk_lat) check("enable_before_latency", int'(char_enable), 0);
      if (c == 3 && chk_lat) check("enable_latency", int'(char_enable), 1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [7:0] addr_before;
    bit         seen;
    for (int i = 0; i < 256; i++) mem[i] = 7'h00;
    mem[8'h10] = 7'h48; mem[8'h11] = 7'h49; mem[8'h12] = 7'h00;
    mem[8'h20] = 7'h41; mem[8'h21] = 7'h0A; mem[8'h22] = 7'h42;
    mem[8'h30] = 7'h41; mem[8'h31] = 7'h42; mem[8'h32] = 7'h43; mem[8'h33] = 7'h44;
    mem[8'h40] = 7'h58; mem[8'h41] = 7'h59;
    mem[8'h50] = 7'h5A;
    fin_ok = 1'b1;
    start = 1'b0; text_base = '0; max_len = '0; origin_x = '0; origin_y = '0;
    size = '0; wrap_x = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_enable", int'(char_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_char_xy", int'({char_x, char_y}), 0);
    resetn = 1'b1;
    @(negedge clock);

    // "HI\0", size 2: H at (10,20), I at 10+12
    push_glyph(7'h48, 10, 20, 2); push_glyph(7'h49, 22, 20, 2); push_done();
    run(8'h10, 8'd8, 10, 20, 2, 300, 1'b1, 1'b1);

    // "A\nB": newline moves down by 8, no glyph for 0x0A
    push_glyph(7'h41, 0, 0, 1); push_glyph(7'h42, 0, 8, 1); push_done();
    run(8'h20, 8'd3, 0, 0, 1, 300, 1'b1, 1'b1);

    // "ABCD", wrap_x 20: D at 18 would end at 23 > 20, so it wraps
    push_glyph(7'h41, 0, 0, 1); push_glyph(7'h42, 6, 0, 1);
    push_glyph(7'h43, 12, 0, 1); push_glyph(7'h44, 0, 8, 1); push_done();
    run(8'h30, 8'd4, 0, 0, 1, 20, 1'b1, 1'b1);

    // max_len 0: immediate done, no address load
    addr_before = mem_addr;
    push_done();
    run(8'h40, 8'd0, 0, 0, 1, 300, 1'b0, 1'b0);
    check("len0_mem_addr", int'(mem_addr), int'(addr_before));

    // max_len 1 over "XY": only X renders
    push_glyph(7'h58, 5, 5, 3); push_done();
    run(8'h40, 8'd1, 5, 5, 3, 300, 1'b1, 1'b1);

    // origin_y 235: 235+7 > 240, no render
    push_done();
    run(8'h50, 8'd1, 0, 235, 1, 300, 1'b1, 1'b0);

    // size 0 is reported as 1
    push_glyph(7'h5A, 0, 0, 1); push_done();
    run(8'h50, 8'd1, 0, 0, 0, 300, 1'b1, 1'b1);

    // Reset mid-render with the renderer never finishing
    fin_ok = 1'b0;
    push_glyph(7'h5A, 7, 9, 1);
    text_base = 8'h50; max_len = 8'd1; origin_x = 9'd7; origin_y = 8'd9;
    size = 4'd1; wrap_x = 9'd300; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (char_enable) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("render_timeout", 0, 1);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_enable", int'(char_enable), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clock);
    resetn = 1'b1;
    fin_ok = 1'b1;
    @(negedge clock);
    push_glyph(7'h5A, 7, 9, 1); push_done();
    run(8'h50, 8'd1, 7, 9, 1, 300, 1'b1, 1'b1);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Walks a NUL-terminated ASCII string held in a synchronous text RAM and drives the character renderer one glyph at a time.
- Maintains a cursor, advances it per glyph scaled by size, and handles newline, space and right-edge wrap.
- Sits directly upstream of the character renderer; its char/origin/size/enable outputs connect to that block, and its finished input comes back from it.

Parameters:
- ADDR_W, 8, text RAM address width
- X_W, 9, screen x coordinate width
- Y_W, 8, screen y coordinate width
- SIZE_W, 4, pixel scale width
- FONT_W, 5, glyph width in font pixels
- FONT_H, 7, glyph height in font pixels
- Y_LIMIT, 240, first y row outside the screen

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- text_base  in  ADDR_W  RAM address of the first character
- max_len  in  ADDR_W  maximum characters to process
- origin_x  in  X_W  left margin and starting x
- origin_y  in  Y_W  starting y
- size  in  SIZE_W  scale factor; 0 is treated as 1
- wrap_x  in  X_W  right bound (exclusive)
- mem_addr  out  ADDR_W  text RAM read address (registered)
- mem_rdata  in  7  RAM data, valid the cycle after the address edge
- char  out  7  glyph code to the character renderer
- char_x  out  X_W  glyph origin x
- char_y  out  Y_W  glyph origin y
- char_size  out  SIZE_W  effective size (never 0)
- char_enable  out  1  render request, level
- char_finished  in  1  renderer completion flag
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-low: clock is the only clock; when resetn=0 at an edge, all outputs, the cursor and the count go to 0 and state goes to IDLE. This applies mid-render as well; the renderer clears itself when char_enable drops.
- Inputs are latched at start: base, len, origin, size, wrap_x. Later changes are ignored until the next start.
- States: IDLE, FETCH, DECODE, RENDER, RELEASE, ADVANCE, DONE.
- IDLE, start=1:
  - Latch inputs, cursor=(origin_x, origin_y), count=0, busy=1.
  - If max_len=0, go to DONE; otherwise mem_addr<=text_base and go to FETCH.
- FETCH: one wait cycle, then DECODE.
- DECODE: register mem_rdata as the current character.
  - 0x00: go to DONE.
  - 0x0A (newline): x=origin_x, y+=size*(FONT_H+1), go to ADVANCE.
  - 0x20 (space): x+=size*(FONT_W+1), go to ADVANCE.
  - Otherwise, if x+size*FONT_W > wrap_x and x != origin_x, wrap first: x=origin_x, y+=size*(FONT_H+1).
  - Then, if y+size*FONT_H > Y_LIMIT, go to DONE without rendering.
  - Else drive char, char_x, char_y, char_size, set char_enable=1, go to RENDER.
- RENDER: hold char_enable and all char outputs stable until char_finished=1. Then char_enable<=0, x+=size*(FONT_W+1), go to RELEASE.
- RELEASE: char_enable stays low for exactly one cycle so the renderer resets before the next glyph.
- ADVANCE: count+1. If count+1=max_len, go to DONE; else mem_addr+1 and go to FETCH.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in DONE is ignored.
- Arithmetic: all cursor sums are computed at X_W+1 / Y_W+1 bits so overflow is seen as "exceeds bound", never a wrap-around.
- Address wrap: mem_addr wraps modulo 2^ADDR_W.
- A glyph wider than the full line (cursor at origin_x) still renders once, clipped downstream.
- Latency:
  - For a printable first character, char_enable rises at the third edge after start is sampled (edges: start accepted, FETCH, DECODE).
  - Per-glyph overhead outside RENDER is 4 cycles (RELEASE, ADVANCE, FETCH, DECODE).
- char_finished is ignored outside RENDER.

Test Plan:
- "HI\0" at base 0x10, origin (10,20), size 2, wrap_x 300, renderer model finishing 5 cycles after enable → glyphs at (10,20) then (22,20); done 1 cycle after the 0x00 decode; exactly 2 enable pulses; each low gap ≥1 cycle.
- "A\nB", size 1, origin (0,0) → A at (0,0), B at (0,8); no enable for 0x0A.
- wrap_x 20, size 1, "ABCD", origin 0 → x = 0, 6, 12; D wraps to (0,8) because 18+5 > 20.
- max_len 0, then max_len 1 with "XY" → the first gives done with no enable and no RAM read beyond base; the second renders X only.
- origin_y 235, size 1, "Z" → 235+7 > 240, so done with no render; with size 0 and origin_y 0, char_size reads 1.
- resetn=0 during RENDER with finished never asserted → the next cycle shows char_enable=0, busy=0, done=0, and state IDLE; start is then accepted normally.
